// File: rtl/sel_rr.sv
// sel_rr: CH-to-1 stream selector with fixed (sel) or round-robin arbitration and a registered output stage.
// Optional packet lock (adds in_last) when SEL_RR_PKT_LOCK_EN is defined.
module sel_rr #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SW    = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic [CH-1:0]       in_valid,
`ifdef SEL_RR_PKT_LOCK_EN
    input  logic [CH-1:0]       in_last,
`endif
    output logic [CH-1:0]       in_ready,
    input  logic                mode,
    input  logic [SW-1:0]       sel,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SW-1:0]       grant
);
    logic [SW-1:0]    ptr, rr_idx, gidx;
    logic [WIDTH-1:0] gdata;
    logic             hit, free, accept, adv;
`ifdef SEL_RR_PKT_LOCK_EN
    logic             lock, last;
    logic [SW-1:0]    lock_ch;
`endif
    assign free   = !out_valid || out_ready;
    assign accept = rst_n && free && hit;
    always_comb begin
        rr_idx = ptr;
        // descending scan so the smallest offset from ptr wins
        for (int i = CH - 1; i >= 0; i--)
            if (in_valid[(int'(ptr) + i) % CH]) rr_idx = SW'((int'(ptr) + i) % CH);
`ifdef SEL_RR_PKT_LOCK_EN
        gidx = lock ? lock_ch : mode ? rr_idx : sel;
        last = 1'b0;
`else
        gidx = mode ? rr_idx : sel;
`endif
        hit   = 1'b0;
        gdata = '0;
        for (int c = 0; c < CH; c++)
            if (int'(gidx) == c) begin
                hit   = in_valid[c];
                gdata = in_data[c*WIDTH +: WIDTH];
`ifdef SEL_RR_PKT_LOCK_EN
                last  = in_last[c];
`endif
            end
        for (int c = 0; c < CH; c++) in_ready[c] = accept && int'(gidx) == c;
`ifdef SEL_RR_PKT_LOCK_EN
        adv = accept && mode && last;
`else
        adv = accept && mode;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant     <= '0;
            ptr       <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                grant     <= gidx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (adv) ptr <= (int'(gidx) == CH - 1) ? '0 : gidx + 1'b1;
        end
    end
`ifdef SEL_RR_PKT_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock    <= 1'b0;
            lock_ch <= '0;
        end else if (accept) begin
            lock    <= !last;
            lock_ch <= gidx;
        end
    end
`endif
endmodule

// File: tb/tb_sel_rr.sv
// tb_sel_rr: table-driven check of sel_rr (CH=4, WIDTH=8, SW=3 so out-of-range sel is reachable).
module tb_sel_rr;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  grant;
    int          n_cmp = 0;
    int          n_bad = 0;

    sel_rr #(.WIDTH(8), .CH(4), .SW(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
`ifdef SEL_RR_PKT_LOCK_EN
        .in_last(in_last),
`endif
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [2:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [7:0] od;
        logic [2:0] gnt;
    } vec_t;

    vec_t tv[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // ch0=11 ch1=22 ch2=A5 ch3=44
        in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        in_last = 4'b1111;
        tv[0]  = '{1'b0, 3'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 3'd2};
        tv[1]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 3'd0};
        tv[2]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 3'd1};
        tv[3]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 3'd2};
        tv[4]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 3'd3};
        tv[5]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 3'd0};
        tv[6]  = '{1'b1, 3'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd0};
        tv[7]  = '{1'b1, 3'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 3'd3};
        tv[8]  = '{1'b1, 3'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'h11, 3'd0};
        tv[9]  = '{1'b0, 3'd5, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd0};
        tv[10] = '{1'b0, 3'd5, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd0};
        tv[11] = '{1'b0, 3'd1, 4'b0101, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd0};
        tv[12] = '{1'b0, 3'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'h44, 3'd3};
        tv[13] = '{1'b1, 3'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h44, 3'd3};
        tv[14] = '{1'b0, 3'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h44, 3'd3};
        tv[15] = '{1'b1, 3'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h44, 3'd3};
        tv[16] = '{1'b1, 3'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 3'd1};
        tv[17] = '{1'b1, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h22, 3'd1};
        tv[18] = '{1'b1, 3'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd0};
        tv[19] = '{1'b1, 3'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 3'd2};

        rst_n = 1'b0; mode = 1'b0; sel = 3'd2; in_valid = 4'b1111; out_ready = 1'b1;
        #2;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_od", 32'(out_data), 0);
        chk("rst_gnt", 32'(grant), 0);
        chk("rst_rdy", 32'(in_ready), 0);
        @(posedge clk);
        @(posedge clk);
        in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            mode = tv[i].mode; sel = tv[i].sel; in_valid = tv[i].valid; out_ready = tv[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(tv[i].rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tv[i].ov));
            if (tv[i].ov) begin
                chk($sformatf("v%0d_od", i), 32'(out_data), 32'(tv[i].od));
                chk($sformatf("v%0d_gnt", i), 32'(grant), 32'(tv[i].gnt));
            end
        end

        // asynchronous reset while a beat is held, then restart from channel 0
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", 32'(out_valid), 0);
        chk("arst_od", 32'(out_data), 0);
        chk("arst_gnt", 32'(grant), 0);
        chk("arst_rdy", 32'(in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("rel_rdy", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        chk("rel_ov", 32'(out_valid), 1);
        chk("rel_gnt", 32'(grant), 0);
        chk("rel_od", 32'(out_data), 32'h11);

`ifdef SEL_RR_PKT_LOCK_EN
        // pointer is now 1: ch1 packet of 3 beats locks out ch0/ch2, mode change ignored mid-packet
        in_valid = 4'b0111; in_last = 4'b0000; mode = 1'b1;
        @(posedge clk); #1;
        chk("lk1_gnt", 32'(grant), 1);
        mode = 1'b0; sel = 3'd0;
        @(posedge clk); #1;
        chk("lk2_gnt", 32'(grant), 1);
        mode = 1'b1; in_last = 4'b0010;
        @(posedge clk); #1;
        chk("lk3_gnt", 32'(grant), 1);
        in_valid = 4'b0101; in_last = 4'b1111;
        @(posedge clk); #1;
        chk("lk4_gnt", 32'(grant), 2);
        chk("lk4_od", 32'(out_data), 32'hA5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sel_rr.md
SEL_RR -- requirements
Module: sel_rr

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel (1..64).
REQ-002 Parameter CH, default 4, input channel count (2..16).
REQ-003 Parameter SW, default $clog2(CH), select/grant index width.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 IN_DATA  input  CH*WIDTH  channel c data occupies bits [c*WIDTH +: WIDTH].
REQ-007 IN_VALID  input  CH  per-channel valid.
REQ-008 IN_READY  output  CH  per-channel ready; channel c beat accepted when IN_VALID[c] and IN_READY[c] are both high.
REQ-009 MODE  input  1  0 = fixed select by SEL, 1 = round-robin.
REQ-010 SEL  input  SW  channel index used when MODE=0.
REQ-011 OUT_DATA  output  WIDTH  registered selected data.
REQ-012 OUT_VALID  output  1  OUT_DATA holds a beat.
REQ-013 OUT_READY  input  1  downstream accepts a beat when OUT_VALID and OUT_READY are both high.
REQ-014 GRANT  output  SW  registered index of the channel that supplied OUT_DATA.

Function
REQ-015 Output register is free when OUT_VALID=0 or OUT_READY=1 in the same cycle.
REQ-016 At most one IN_READY bit is high per cycle, and only for the granted channel while the output register is free.
REQ-017 Latency: a beat accepted in cycle n appears on OUT_DATA/OUT_VALID in cycle n+1; full throughput of one beat per cycle while OUT_READY=1.
REQ-018 MODE=0: candidate = SEL; no grant when SEL >= CH or IN_VALID[SEL]=0.
REQ-019 MODE=1: candidate = first valid channel searching upward from the priority pointer, wrapping CH-1 to 0.
REQ-020 After each accepted beat in MODE=1, the pointer becomes (granted index + 1) mod CH; the pointer is unchanged when no beat is accepted or when MODE=0.
REQ-021 OUT_VALID clears after a downstream accept when no new beat is accepted in the same cycle; simultaneous accept and load replaces the data without a bubble.
REQ-022 When OUT_VALID=1 and OUT_READY=0, OUT_DATA and GRANT are held stable and all IN_READY bits are low.
REQ-023 MODE and SEL changes take effect at the next arbitration cycle and never corrupt a held output beat.

Reset
REQ-024 While RST_N=0: OUT_VALID=0, OUT_DATA=0, GRANT=0, priority pointer=0, IN_READY all 0, lock flag clear.
REQ-025 Reset assertion mid-transfer discards the held beat immediately; the first arbitration after release starts from channel 0.

Configuration
REQ-026 Macro SEL_RR_PKT_LOCK_EN: when defined, an input IN_LAST [CH] is added, and after a granted beat with IN_LAST[c]=0 the grant locks to channel c, ignoring MODE, SEL and the pointer, until a beat with IN_LAST[c]=1 is accepted.
REQ-027 With SEL_RR_PKT_LOCK_EN defined, the round-robin pointer advances only on the beat carrying IN_LAST; the lock flag clears on reset.
REQ-028 Without SEL_RR_PKT_LOCK_EN, IN_LAST is absent and every beat is an independent arbitration point.

Verification
REQ-029 MODE=0, SEL=2, IN_VALID=4'b1111, ch2 data=8'hA5, OUT_READY=1 -> OUT_DATA=8'hA5 and GRANT=2 one cycle later; only IN_READY[2] is high.
REQ-030 MODE=1, all four channels valid continuously, OUT_READY=1 -> GRANT sequence 0,1,2,3,0 on consecutive cycles.
REQ-031 OUT_READY=0 for 3 cycles with OUT_VALID=1 -> OUT_DATA/GRANT constant, IN_READY=0; OUT_READY=1 -> next beat loads with no bubble.
REQ-032 MODE=0, SEL=5 with CH=4 -> IN_READY all 0 and OUT_VALID stays 0.
REQ-033 RST_N pulled low while OUT_VALID=1 -> OUT_VALID=0 asynchronously; after release with all channels valid in MODE=1, first GRANT=0.
REQ-034 With SEL_RR_PKT_LOCK_EN defined, MODE=1, ch1 sends 3 beats (IN_LAST on the 3rd) while ch0 and ch2 are valid -> GRANT=1,1,1 then 2.
